jstk_poll_ctrl: RTL and testbench
=================================

Name: jstk_poll_ctrl

Overview:
Sequencer for the SPI joystick link. Periodically, or on request, it launches one 5-byte SPI transaction through the existing SPI master and waits for completion. It then decodes the received bytes into X/Y position and buttons, and publishes them with a one-cycle valid strobe. It sits between the SPI master and game logic (paddle control, display), and owns the LED command byte sent to the joystick.

Parameters:
POLL_DIV, 50000, clk50M cycles between automatic poll launches (1 kHz at 50 MHz); minimum 16
TIMEOUT, 4096, cycles allowed from spi_start to spi_done before abort
DEADZONE, 16, half-width of centre deadzone around 512 (used only with the optional feature)

Ports:
clk50M  in  1  system clock, 50 MHz
rst_n  in  1  asynchronous active-low reset
poll_req  in  1  single-cycle request for an immediate poll
led_cmd  in  2  joystick LED bits, sampled at launch
spi_start  out  1  one-cycle pulse starting an SPI transaction
spi_tx  out  40  transmit bytes, first byte in [39:32]
spi_rx  in  40  received bytes, first byte in [39:32]; valid when spi_done=1
spi_done  in  1  one-cycle completion pulse from the SPI master
x_pos  out  10  decoded X position
y_pos  out  10  decoded Y position
buttons  out  3  decoded buttons {b2,b1,b0}
sample_valid  out  1  one-cycle strobe: x_pos/y_pos/buttons updated
timeout_err  out  1  sticky: a transaction timed out; cleared by the next good sample
busy  out  1  high from launch to return to IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE, spi_start=0, spi_tx=0, x_pos=512, y_pos=512, buttons=0, sample_valid=0, timeout_err=0, busy=0, poll counter=0, pending=0.
- Poll counter: free-runs 0..POLL_DIV-1 in every state; wraps to 0 and raises a tick on reaching POLL_DIV-1.
- pending: set by a tick or poll_req in any state; cleared on launch. Multiple events while busy collapse into one poll.
- States:
  - IDLE: if pending or tick/poll_req this cycle -> LAUNCH.
  - LAUNCH (1 cycle): spi_start=1; spi_tx={6'b100000, led_cmd, 32'h0}; clear pending and the timeout counter; busy=1 -> WAIT.
  - WAIT: timeout counter increments.
    - spi_done=1 -> register spi_rx -> DECODE.
    - Counter reaches TIMEOUT-1 without spi_done -> set timeout_err; outputs unchanged -> IDLE.
    - spi_done on the same cycle as the timeout -> done wins.
  - DECODE (1 cycle):
    - x_pos = {rx[25:24], rx[39:32]}
    - y_pos = {rx[9:8], rx[23:16]}
    - buttons = rx[2:0]
    - sample_valid=1 for exactly this cycle; timeout_err cleared -> IDLE; busy=0 from IDLE onward.
- spi_tx holds its last value after launch, so the SPI master may sample it late.
- spi_done seen in IDLE or LAUNCH is ignored.
- Launch latency: a request in IDLE produces spi_start on the next cycle. sample_valid follows spi_done by 2 cycles.
- All outputs are registered. Reset mid-transaction aborts immediately to reset values; a late spi_done after reset is ignored.

Optional Feature:
Macro JSTK_DEADZONE_EN.
- Defined: in DECODE, each axis with |value-512| <= DEADZONE is output as exactly 512. Comparison is on 11-bit signed difference.
- Undefined: raw decoded values pass through. The DEADZONE parameter is present but unused.

Decomposition:
- Shared package jstk_pkg holds:
  - state enum (IDLE, LAUNCH, WAIT, DECODE)
  - JSTK_CMD_HDR = 6'b100000
  - JSTK_CENTER = 10'd512
  - byte-field offset constants for the X/Y/button decode
- One natural sub-module, jstk_decode: combinational 40-bit to {x, y, buttons} decode, including the deadzone clamp. It is reusable by display debug logic.

Test Plan:
- Reset release, no requests, POLL_DIV=100 -> first spi_start at cycle 100; spi_tx=40'h80_00000000 with led_cmd=0.
- poll_req in IDLE, led_cmd=2'b11 -> spi_start next cycle; spi_tx[39:32]=8'h83.
- spi_done with spi_rx=40'h34_02_C8_01_05 -> 2 cycles later x_pos=564, y_pos=456, buttons=3'b101, sample_valid high for exactly 1 cycle.
- spi_done withheld -> timeout_err=1 after TIMEOUT cycles, x_pos/y_pos unchanged, state returns to IDLE; the next good transaction clears timeout_err.
- Three poll_req pulses plus a tick while in WAIT -> exactly one further spi_start after DECODE.
- rst_n asserted mid-WAIT -> outputs at reset values immediately; a following spi_done produces no sample_valid.
- With JSTK_DEADZONE_EN, DEADZONE=16, X raw 520 -> 512 and X raw 530 -> 530.

Source files
------------

// File: rtl/jstk_pkg.sv
// jstk_pkg: shared FSM state, command header and byte-field offsets for the joystick poll controller
package jstk_pkg;
   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DECODE} jstk_state_t;
   localparam logic [5:0] JSTK_CMD_HDR = 6'b100000;
   localparam logic [9:0] JSTK_CENTER = 10'd512;
   localparam int X_LSB_BYTE = 32;
   localparam int X_MSB_BITS = 24;
   localparam int Y_LSB_BYTE = 16;
   localparam int Y_MSB_BITS = 8;
   localparam int BTN_BITS = 0;
endpackage

// File: rtl/jstk_poll_ctrl_if.sv
// jstk_poll_ctrl_if: SPI master handshake between the poll controller and the SPI master
interface jstk_poll_ctrl_if;
   logic        spi_start;
   logic [39:0] spi_tx;
   logic [39:0] spi_rx;
   logic        spi_done;
   modport master (output spi_start, spi_tx, input spi_rx, spi_done);
   modport slave (input spi_start, spi_tx, output spi_rx, spi_done);
endinterface

// File: rtl/jstk_decode.sv
// jstk_decode: 40-bit joystick frame to {x, y, buttons}; JSTK_DEADZONE_EN snaps near-centre axes to 512
module jstk_decode
   import jstk_pkg::*;
#(
   parameter int DEADZONE = 16
) (
   input  logic [39:0] rx,
   output logic [9:0]  x,
   output logic [9:0]  y,
   output logic [2:0]  buttons
);
`ifdef JSTK_DEADZONE_EN
   localparam bit DZ_EN = 1'b1;
`else
   localparam bit DZ_EN = 1'b0;
`endif
   localparam logic signed [10:0] DZ = 11'(DEADZONE);
   logic [9:0] x_raw, y_raw;
   logic signed [10:0] dx, dy;
   logic unused_bits;
   always_comb begin
      x_raw = {rx[X_MSB_BITS+1:X_MSB_BITS], rx[X_LSB_BYTE+7:X_LSB_BYTE]};
      y_raw = {rx[Y_MSB_BITS+1:Y_MSB_BITS], rx[Y_LSB_BYTE+7:Y_LSB_BYTE]};
      dx = $signed({1'b0, x_raw}) - $signed({1'b0, JSTK_CENTER});
      dy = $signed({1'b0, y_raw}) - $signed({1'b0, JSTK_CENTER});
      x = (DZ_EN && dx >= -DZ && dx <= DZ) ? JSTK_CENTER : x_raw;
      y = (DZ_EN && dy >= -DZ && dy <= DZ) ? JSTK_CENTER : y_raw;
      buttons = rx[BTN_BITS+2:BTN_BITS];
   end
   assign unused_bits = ^{rx[31:26], rx[15:10], rx[7:3]};
endmodule

// File: rtl/jstk_poll_ctrl.sv
// jstk_poll_ctrl: periodic/on-demand 5-byte SPI joystick poll, decode and publish
// Optional centre deadzone clamp enabled by defining JSTK_DEADZONE_EN.
module jstk_poll_ctrl
   import jstk_pkg::*;
#(
   parameter int POLL_DIV = 50000,
   parameter int TIMEOUT  = 4096,
   parameter int DEADZONE = 16
) (
   input  logic             clk50M,
   input  logic             rst_n,
   input  logic             poll_req,
   input  logic [1:0]       led_cmd,
   jstk_poll_ctrl_if.master spi,
   output logic [9:0]       x_pos,
   output logic [9:0]       y_pos,
   output logic [2:0]       buttons,
   output logic             sample_valid,
   output logic             timeout_err,
   output logic             busy
);
   localparam int PW = $clog2(POLL_DIV);
   localparam int TW = $clog2(TIMEOUT);
   localparam logic [PW-1:0] POLL_LAST = PW'(POLL_DIV - 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
   jstk_state_t state;
   logic [PW-1:0] poll_cnt;
   logic [TW-1:0] to_cnt;
   logic [39:0] rx_q;
   logic pending, tick, go;
   logic [9:0] dec_x, dec_y;
   logic [2:0] dec_b;
   assign tick = poll_cnt == POLL_LAST;
   assign go = state == IDLE && (pending || tick || poll_req);
   jstk_decode #(.DEADZONE(DEADZONE)) u_decode (
      .rx(rx_q), .x(dec_x), .y(dec_y), .buttons(dec_b)
   );
   always_ff @(posedge clk50M or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         poll_cnt <= '0;
         to_cnt <= '0;
         pending <= 1'b0;
         rx_q <= '0;
         spi.spi_start <= 1'b0;
         spi.spi_tx <= '0;
         x_pos <= JSTK_CENTER;
         y_pos <= JSTK_CENTER;
         buttons <= '0;
         sample_valid <= 1'b0;
         timeout_err <= 1'b0;
         busy <= 1'b0;
      end else begin
         poll_cnt <= tick ? '0 : poll_cnt + 1'b1;
         pending <= go ? 1'b0 : pending | tick | poll_req;
         spi.spi_start <= go;
         sample_valid <= 1'b0;
         case (state)
            IDLE: if (go) begin
               state <= LAUNCH;
               spi.spi_tx <= {JSTK_CMD_HDR, led_cmd, 32'h0};
               to_cnt <= '0;
               busy <= 1'b1;
            end
            LAUNCH: state <= WAIT;
            WAIT: if (spi.spi_done) begin
               rx_q <= spi.spi_rx;
               state <= DECODE;
            end else if (to_cnt == TO_LAST) begin
               timeout_err <= 1'b1;
               busy <= 1'b0;
               state <= IDLE;
            end else begin
               to_cnt <= to_cnt + 1'b1;
            end
            DECODE: begin
               x_pos <= dec_x;
               y_pos <= dec_y;
               buttons <= dec_b;
               sample_valid <= 1'b1;
               timeout_err <= 1'b0;
               busy <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_jstk_poll_ctrl.sv
// tb_jstk_poll_ctrl: randomized and directed check of jstk_poll_ctrl against a timestamp-based reference model
module tb_jstk_poll_ctrl;
   localparam int POLL_DIV = 100;
   localparam int TIMEOUT  = 40;
   localparam int DZ       = 16;

   logic clk50M = 1'b0;
   logic rst_n = 1'b0;
   logic poll_req = 1'b0;
   logic [1:0] led_cmd = 2'b00;
   logic [9:0] x_pos, y_pos;
   logic [2:0] buttons;
   logic sample_valid, timeout_err, busy;

   jstk_poll_ctrl_if spi_if ();

   jstk_poll_ctrl #(.POLL_DIV(POLL_DIV), .TIMEOUT(TIMEOUT), .DEADZONE(DZ)) dut (
      .clk50M(clk50M), .rst_n(rst_n), .poll_req(poll_req), .led_cmd(led_cmd), .spi(spi_if.master),
      .x_pos(x_pos), .y_pos(y_pos), .buttons(buttons),
      .sample_valid(sample_valid), .timeout_err(timeout_err), .busy(busy)
   );

   always #10 clk50M = ~clk50M;

   int ncmp = 0, nerr = 0;
   int cyc;
   // reference model: timestamps of launch, sample and when the controller is free again
   bit inflight, pend;
   int t_launch, free_at, samp_at, done_at;
   logic [9:0] sx, sy;
   logic [2:0] sb;
   logic e_start, e_valid, e_err, e_busy;
   logic [39:0] e_tx;
   logic [9:0] e_x, e_y;
   logic [2:0] e_b;
   // stimulus controls
   int lat;
   bit req_now, rand_req, stray, fixed_rx, fixed_led;
   logic [39:0] rx_val;
   logic [1:0] led_val;
   // observations for the literal checks
   int last_start, last_valid, starts, valids;
   logic [39:0] last_tx;

   task automatic cmp(input string n, input logic [39:0] act, input logic [39:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", n, cyc, act, exp);
      end
   endtask

   function automatic logic [22:0] ref_dec(input logic [39:0] rx);
      int b[5];
      int x, y;
      for (int i = 0; i < 5; i++) b[i] = int'((rx >> (8 * (4 - i))) & 40'hFF);
      x = (b[1] % 4) * 256 + b[0];
      y = (b[3] % 4) * 256 + b[2];
`ifdef JSTK_DEADZONE_EN
      if (x - 512 <= DZ && 512 - x <= DZ) x = 512;
      if (y - 512 <= DZ && 512 - y <= DZ) y = 512;
`endif
      return {10'(x), 10'(y), 3'(b[4] % 8)};
   endfunction

   task automatic mreset();
      cyc = 0; inflight = 0; pend = 0; t_launch = -1000; free_at = 0; samp_at = -1; done_at = -1;
      e_start = 0; e_valid = 0; e_err = 0; e_busy = 0; e_tx = '0; e_x = 10'd512; e_y = 10'd512; e_b = '0;
   endtask

   task automatic check_all();
      cmp("spi_start", 40'(spi_if.spi_start), 40'(e_start));
      cmp("spi_tx", spi_if.spi_tx, e_tx);
      cmp("x_pos", 40'(x_pos), 40'(e_x));
      cmp("y_pos", 40'(y_pos), 40'(e_y));
      cmp("buttons", 40'(buttons), 40'(e_b));
      cmp("sample_valid", 40'(sample_valid), 40'(e_valid));
      cmp("timeout_err", 40'(timeout_err), 40'(e_err));
      cmp("busy", 40'(busy), 40'(e_busy));
   endtask

   // one cycle: compare outputs of cycle cyc, drive inputs for cyc, advance model to cyc+1
   task automatic step();
      bit ev, go;
      logic [22:0] d;
      check_all();
      if (spi_if.spi_start === 1'b1) begin last_start = cyc; last_tx = spi_if.spi_tx; starts++; end
      if (sample_valid === 1'b1) begin last_valid = cyc; valids++; end
      poll_req = req_now || (rand_req && $urandom_range(0, 29) == 0);
      req_now = 0;
      led_cmd = fixed_led ? led_val : 2'($urandom);
      spi_if.spi_rx = {$urandom, 8'($urandom)};
      spi_if.spi_done = (cyc == done_at) || (stray && $urandom_range(0, 49) == 0);
      if (cyc == done_at && fixed_rx) spi_if.spi_rx = rx_val;
      ev = poll_req || (cyc % POLL_DIV == POLL_DIV - 1);
      e_start = 0;
      e_valid = 0;
      if (inflight && cyc > t_launch && spi_if.spi_done) begin
         inflight = 0; samp_at = cyc + 2; free_at = cyc + 2;
         d = ref_dec(spi_if.spi_rx);
         {sx, sy, sb} = d;
      end else if (inflight && cyc == t_launch + TIMEOUT) begin
         inflight = 0; free_at = cyc + 1; e_err = 1; e_busy = 0;
      end
      if (cyc + 1 == samp_at) begin
         e_valid = 1; e_x = sx; e_y = sy; e_b = sb; e_err = 0; e_busy = 0;
      end
      go = !inflight && cyc >= free_at && (pend || ev);
      if (go) begin
         t_launch = cyc + 1; inflight = 1; pend = 0; free_at = 1 << 30;
         e_start = 1; e_busy = 1; e_tx = {6'b100000, led_cmd, 32'h0};
         done_at = lat < 0 ? t_launch + $urandom_range(1, TIMEOUT + 6) : lat == 0 ? -1 : t_launch + lat;
      end else if (ev) pend = 1;
      cyc++;
   endtask

   task automatic run_to(input int target);
      while (cyc < target) begin
         @(negedge clk50M);
         step();
      end
   endtask

   task automatic release_reset();
      @(negedge clk50M);
      rst_n = 1'b1;
      mreset();
      step();
   endtask

   int n, s0, v0;

   initial begin
      spi_if.spi_done = 1'b0;
      spi_if.spi_rx = '0;
      lat = 3; req_now = 0; rand_req = 0; stray = 0; fixed_rx = 1; fixed_led = 1;
      rx_val = 40'h34_02_C8_01_05; led_val = 2'b00;
      last_start = -1; last_valid = -1; starts = 0; valids = 0; last_tx = '0;
      mreset();
      repeat (3) @(posedge clk50M);
      release_reset();
      // automatic poll and first sample
      run_to(106);
      cmp("first_start_cycle", 40'(last_start), 40'd100);
      cmp("first_tx", last_tx, 40'h80_0000_0000);
      cmp("first_valid_cycle", 40'(last_valid), 40'd105);
      cmp("first_valid_count", 40'(valids), 40'd1);
      cmp("first_x", 40'(x_pos), 40'd564);
      cmp("first_y", 40'(y_pos), 40'd456);
      cmp("first_buttons", 40'(buttons), 40'b101);
      // poll_req in IDLE with LEDs on
      run_to(120);
      led_val = 2'b11; req_now = 1;
      run_to(122);
      cmp("req_start_cycle", 40'(last_start), 40'd121);
      cmp("req_tx_byte0", 40'(last_tx[39:32]), 40'h83);
      // withheld spi_done times out, then a good sample clears the error
      run_to(140);
      lat = 0; req_now = 1;
      run_to(183);
      cmp("timeout_err_set", 40'(timeout_err), 40'd1);
      cmp("timeout_busy", 40'(busy), 40'd0);
      cmp("timeout_x_held", 40'(x_pos), 40'd564);
      lat = 3;
      run_to(206);
      cmp("timeout_err_cleared", 40'(timeout_err), 40'd0);
      cmp("recover_valid_cycle", 40'(last_valid), 40'd205);
      // three requests and a tick during WAIT collapse into one poll
      run_to(290);
      lat = 30; req_now = 1;
      run_to(292);
      lat = 3; s0 = starts;
      run_to(295); req_now = 1;
      run_to(300); req_now = 1;
      run_to(305); req_now = 1;
      run_to(380);
      cmp("collapsed_start_count", 40'(starts - s0), 40'd1);
      cmp("collapsed_start_cycle", 40'(last_start), 40'd324);
      // deadzone boundary on X
      run_to(410);
      rx_val = 40'h08_02_00_02_00; req_now = 1;
      run_to(417);
`ifdef JSTK_DEADZONE_EN
      cmp("x_520", 40'(x_pos), 40'd512);
`else
      cmp("x_520", 40'(x_pos), 40'd520);
`endif
      run_to(430);
      rx_val = 40'h12_02_00_02_00; req_now = 1;
      run_to(437);
      cmp("x_530", 40'(x_pos), 40'd530);
      // randomized traffic
      fixed_rx = 0; fixed_led = 0; lat = -1; rand_req = 1; stray = 1;
      run_to(4000);
      // reset in the middle of WAIT
      rand_req = 0; stray = 0; lat = 0; req_now = 1; n = 0;
      while (!(inflight && cyc >= t_launch + 3) && n < 400) begin
         @(negedge clk50M);
         step();
         n++;
      end
      cmp("reach_wait_in_budget", 40'(n < 400), 40'd1);
      rst_n = 1'b0;
      spi_if.spi_done = 1'b0;
      poll_req = 1'b0;
      #1;
      cmp("rst_busy", 40'(busy), 40'd0);
      cmp("rst_x", 40'(x_pos), 40'd512);
      cmp("rst_y", 40'(y_pos), 40'd512);
      cmp("rst_start", 40'(spi_if.spi_start), 40'd0);
      cmp("rst_tx", spi_if.spi_tx, 40'd0);
      cmp("rst_err", 40'(timeout_err), 40'd0);
      v0 = valids;
      repeat (3) @(posedge clk50M);
      @(negedge clk50M);
      rst_n = 1'b1;
      mreset();
      done_at = 0;
      step();
      run_to(30);
      cmp("late_done_no_valid", 40'(valids - v0), 40'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule
